// File: rtl/b205_dac_pkg.sv
// Shared definitions for the B205 AD5662 trim-DAC arbiter: frame width,
// power-down codes, FSM states and the frame packing helper.
package b205_dac_pkg;

    localparam int AD5662_FRAME_W = 24;

    typedef enum logic [1:0] {
        PD_NORMAL = 2'b00,
        PD_1K     = 2'b01,
        PD_100K   = 2'b10,
        PD_TRI    = 2'b11
    } pd_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } dac_state_e;

    typedef enum logic [1:0] {
        SRC_INIT,
        SRC_HOST,
        SRC_LOOP
    } dac_src_e;

    // AD5662 input register: 6 don't-care zeros, 2 power-down bits, 16-bit code.
    function automatic logic [AD5662_FRAME_W-1:0] make_frame(input logic [1:0]  pd,
                                                             input logic [15:0] code);
        return {6'b000000, pd, code};
    endfunction

endpackage

// File: rtl/b205_dac_spi_tx.sv
// AD5662 frame serialiser: on start, drops sync_n and shifts 24 bits MSB first.
// mosi changes only with sclk rising so it is stable at the falling edge the DAC
// samples on. done is high in the last cycle of the final low half-period.
module b205_dac_spi_tx
    import b205_dac_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [AD5662_FRAME_W-1:0] frame,
    output logic                      sclk,
    output logic                      mosi,
    output logic                      sync_n,
    output logic                      done
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]        BIT_LAST = 5'(AD5662_FRAME_W - 1);

    logic                      active;
    logic [DIV_W-1:0]          div_cnt;
    logic [4:0]                bit_cnt;
    logic [AD5662_FRAME_W-1:0] shreg;
    logic                      half_end;

    assign half_end = active && (div_cnt == DIV_LAST);
    assign done     = half_end && !sclk && (bit_cnt == BIT_LAST);

    // Half-period timing, bit sequencing and pin drive; reset parks the pins idle
    // immediately so the DAC discards any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values of its neighbours, independent of statement order.
        if (!reset_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk    <= 1'b1;
            mosi    <= 1'b0;
            sync_n  <= 1'b1;
        end else if (start) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= frame;
            mosi    <= frame[AD5662_FRAME_W-1];
            sync_n  <= 1'b0;
            sclk    <= 1'b1;
        end else if (active) begin
            if (!half_end) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                if (sclk) begin
                    sclk <= 1'b0;
                end else if (bit_cnt == BIT_LAST) begin
                    sclk   <= 1'b1;
                    sync_n <= 1'b1;
                    active <= 1'b0;
                end else begin
                    sclk    <= 1'b1;
                    bit_cnt <= bit_cnt + 5'd1;
                    mosi    <= shreg[AD5662_FRAME_W-2];
                    shreg   <= {shreg[AD5662_FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/b205_dac_arbiter.sv
// Owns the AD5662 VCTCXO trim DAC port: power-on init frame, a coalescing loop
// slot and an acknowledged host slot, fixed-priority arbitration, frame sequencing.
module b205_dac_arbiter
    import b205_dac_pkg::*;
#(
    parameter int          CLK_DIV    = 4,
    parameter int          SYNC_GAP   = 4,
    parameter logic [15:0] INIT_VALUE = 16'h7FFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] loop_dat,
    input  logic        loop_stb,
    input  logic [15:0] host_dat,
    input  logic [1:0]  host_pd,
    input  logic        host_stb,
    input  logic        host_override,
    output logic        host_busy,
    output logic        busy,
    output logic [15:0] dac_value,
    output logic [1:0]  dac_pd,
    output logic        sclk,
    output logic        mosi,
    output logic        sync_n
);

    localparam int               GAP_W    = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

    dac_state_e                state_q, state_nxt;
    logic [GAP_W-1:0]          gap_cnt;
    logic                      init_pend, host_vld, loop_vld, ovr_q;
    logic [15:0]               host_code, loop_code, frame_code_q;
    logic [1:0]                host_pd_q, frame_pd_q;
    logic                      frame_host_q;
    dac_src_e                  sel_src;
    logic [AD5662_FRAME_W-1:0] sel_frame;
    logic                      tx_start, tx_done;
    logic                      pending, ovr_rise, loop_accept, host_accept;

    assign busy        = (state_q != ST_IDLE);
    assign pending     = init_pend | host_vld | loop_vld;
    assign ovr_rise    = host_override & ~ovr_q;
    assign host_accept = host_stb & ~host_busy;
    // A loop code that already sits in the DAC is dropped only when nothing could overwrite it.
    assign loop_accept = loop_stb && !host_override &&
                         !(loop_dat == dac_value && dac_pd == PD_NORMAL && !pending && !busy);

    // Fixed priority: power-on init, then host, then loop.
    always_comb begin
        sel_src = SRC_LOOP;
        if (init_pend)     sel_src = SRC_INIT;
        else if (host_vld) sel_src = SRC_HOST;
    end

    // Frame contents for the selected source.
    always_comb begin
        case (sel_src)
            SRC_INIT: sel_frame = make_frame(PD_NORMAL, INIT_VALUE);
            SRC_HOST: sel_frame = make_frame(host_pd_q, host_code);
            default:  sel_frame = make_frame(PD_NORMAL, loop_code);
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_nxt;
    end

    // Next state and the one-cycle serialiser start.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_nxt = state_q;
        tx_start  = 1'b0;
        case (state_q)
            // A loop slot being killed by override this cycle must not open a frame.
            ST_IDLE:  if (init_pend || host_vld || (loop_vld && !ovr_rise)) state_nxt = ST_LOAD;
            ST_LOAD: begin
                tx_start  = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: if (tx_done) state_nxt = ST_GAP;
            ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Inter-frame gap counter, restarted as the frame ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               gap_cnt <= '0;
        else if (tx_done)           gap_cnt <= '0;
        else if (state_q == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
    end

    // Pending slots: LOAD empties the chosen slot, a strobe in the same cycle refills it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_pend <= 1'b1;
            host_vld  <= 1'b0;
            loop_vld  <= 1'b0;
            ovr_q     <= 1'b0;
            host_code <= '0;
            host_pd_q <= PD_NORMAL;
            loop_code <= '0;
        end else begin
            ovr_q <= host_override;
            if (tx_start) begin
                case (sel_src)
                    SRC_INIT: init_pend <= 1'b0;
                    SRC_HOST: host_vld  <= 1'b0;
                    default:  loop_vld  <= 1'b0;
                endcase
            end
            if (ovr_rise) loop_vld <= 1'b0;
            if (loop_accept) begin
                loop_vld  <= 1'b1;
                loop_code <= loop_dat;
            end
            if (host_accept) begin
                host_vld  <= 1'b1;
                host_code <= host_dat;
                host_pd_q <= host_pd;
            end
        end
    end

    // In-flight frame record, host acknowledge and the last-written DAC status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_code_q <= '0;
            frame_pd_q   <= PD_NORMAL;
            frame_host_q <= 1'b0;
            host_busy    <= 1'b0;
            dac_value    <= INIT_VALUE;
            dac_pd       <= PD_NORMAL;
        end else begin
            if (tx_start) begin
                frame_code_q <= sel_frame[15:0];
                frame_pd_q   <= sel_frame[17:16];
                frame_host_q <= (sel_src == SRC_HOST);
            end
            if (host_accept)                host_busy <= 1'b1;
            else if (tx_done && frame_host_q) host_busy <= 1'b0;
            if (tx_done) begin
                dac_value <= frame_code_q;
                dac_pd    <= frame_pd_q;
            end
        end
    end

    b205_dac_spi_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (tx_start),
        .frame   (sel_frame),
        .sclk    (sclk),
        .mosi    (mosi),
        .sync_n  (sync_n),
        .done    (tx_done)
    );

endmodule
